// File: rtl/trackball_cursor_pkg.sv
// Shared types and constants for the trackball cursor plotter.
// Coordinate widths, erase colour and the plus-shape offset table.
package trackball_cursor_pkg;

    localparam int X_W   = 11;
    localparam int Y_W   = 10;
    localparam int PIX_W = 12;

    localparam logic [PIX_W-1:0] ERASE_PIXEL = 12'h000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_POLL  = 2'd1,
        S_ERASE = 2'd2,
        S_DRAW  = 2'd3
    } state_t;

    // Two's-complement offsets: (0,0) (+1,0) (-1,0) (0,+1) (0,-1)
    localparam logic [1:0] OFF_DX [5] = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b00};
    localparam logic [1:0] OFF_DY [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b11};

endpackage

// File: rtl/tb_reg_poller.sv
// Walks the trackball decoder registers 0..3, settling on each address
// before capturing tb_data; pulses o_done after the last capture.
module tb_reg_poller
    import trackball_cursor_pkg::*;
#(
    parameter int SETTLE = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_tb_data,
    output logic [1:0] o_tb_adr,
    output logic [7:0] o_d0,
    output logic [7:0] o_d1,
    output logic [7:0] o_d2,
    output logic [7:0] o_d3,
    output logic       o_done
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic          r_active;
    logic [1:0]    r_adr;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_d0, r_d1, r_d2, r_d3;
    logic          r_done;
    logic          w_last;

    assign w_last = (r_cnt == CW'(SETTLE - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_active <= 1'b0;
            r_adr    <= 2'd0;
            r_cnt    <= '0;
            r_d0     <= 8'd0;
            r_d1     <= 8'd0;
            r_d2     <= 8'd0;
            r_d3     <= 8'd0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_active <= 1'b1;
                r_adr    <= 2'd0;
                r_cnt    <= '0;
            end else if (r_active) begin
                if (w_last) begin
                    r_cnt <= '0;
                    case (r_adr)
                        2'd0:    r_d0 <= i_tb_data;
                        2'd1:    r_d1 <= i_tb_data;
                        2'd2:    r_d2 <= i_tb_data;
                        default: r_d3 <= i_tb_data;
                    endcase
                    // Address wraps back to 0 after the final register
                    r_adr <= r_adr + 2'd1;
                    if (r_adr == 2'd3) begin
                        r_active <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign o_tb_adr = r_adr;
    assign o_d0     = r_d0;
    assign o_d1     = r_d1;
    assign o_d2     = r_d2;
    assign o_d3     = r_d3;
    assign o_done   = r_done;

endmodule

// File: rtl/trackball_cursor_plotter.sv
// Polls the trackball, then erases the old plus-shaped cursor and draws
// the new one through a valid/ready frame-buffer write port.
module trackball_cursor_plotter
    import trackball_cursor_pkg::*;
#(
    parameter int SETTLE      = 8,
    parameter int POLL_PERIOD = 114
) (
    input  logic             GCLK,
    input  logic             reset_n,
    input  logic             poll_en,
    input  logic [7:0]       tb_data,
    output logic [1:0]       tb_adr,
    output logic             fb_we,
    input  logic             fb_ready,
    output logic [X_W-1:0]   fb_x,
    output logic [Y_W-1:0]   fb_y,
    output logic [PIX_W-1:0] fb_pixel,
    output logic [X_W-1:0]   cursor_x,
    output logic [Y_W-1:0]   cursor_y,
    output logic             busy
);

    localparam int PW = $clog2(POLL_PERIOD + 1);

    state_t           r_state;
    logic [PW-1:0]    r_per;
    logic             r_valid;
    logic [PIX_W-1:0] r_color;
    logic [2:0]       r_idx;
    logic             r_we;
    logic [X_W-1:0]   r_x, r_cx;
    logic [Y_W-1:0]   r_y, r_cy;
    logic [PIX_W-1:0] r_pix;

    logic [7:0]       w_d0, w_d1, w_d2, w_d3;
    logic             w_done, w_start, w_per_hit;
    logic [X_W-1:0]   w_new_x, w_bx;
    logic [Y_W-1:0]   w_new_y, w_by;
    logic [PIX_W-1:0] w_new_col, w_bpix;
    logic             w_moved, w_recolor, w_step, w_last;
    state_t           w_nxt;
    logic             w_present;
    logic [2:0]       w_pidx;
    logic [1:0]       w_dx, w_dy;
    logic [X_W:0]     w_sx;
    logic [Y_W:0]     w_sy;
    logic             w_in;
    logic             w_unused;

    tb_reg_poller #(.SETTLE(SETTLE)) u_poller (
        .i_clk     (GCLK),
        .i_rst_n   (reset_n),
        .i_start   (w_start),
        .i_tb_data (tb_data),
        .o_tb_adr  (tb_adr),
        .o_d0      (w_d0),
        .o_d1      (w_d1),
        .o_d2      (w_d2),
        .o_d3      (w_d3),
        .o_done    (w_done)
    );

    assign w_unused  = ^{w_d2[3:0], w_d3[3:0]};
    assign w_new_x   = {w_d0, 3'b000};
    assign w_new_y   = {w_d1, 2'b00};
    assign w_new_col = {w_d2[7:4], w_d3[7:4], 4'hF};
    assign w_moved   = (w_new_x != r_cx) || (w_new_y != r_cy);
    assign w_recolor = (w_new_col != r_color);
    assign w_per_hit = (r_per == PW'(POLL_PERIOD - 1));
    assign w_start   = (r_state == S_IDLE) && poll_en && w_per_hit;
    assign w_step    = !r_we || fb_ready;
    assign w_last    = (r_idx == 3'd4);

    always_comb begin
        w_nxt     = r_state;
        w_present = 1'b0;
        w_pidx    = 3'd0;
        unique case (r_state)
            S_IDLE: if (w_start) w_nxt = S_POLL;
            S_POLL: begin
                if (w_done) begin
                    if (r_valid && w_moved) begin
                        w_nxt     = S_ERASE;
                        w_present = 1'b1;
                    end else if (w_moved || w_recolor || !r_valid) begin
                        w_nxt     = S_DRAW;
                        w_present = 1'b1;
                    end else begin
                        w_nxt = S_IDLE;
                    end
                end
            end
            S_ERASE, S_DRAW: begin
                if (w_step) begin
                    if (!w_last) begin
                        w_present = 1'b1;
                        w_pidx    = r_idx + 3'd1;
                    end else if (r_state == S_ERASE) begin
                        w_nxt     = S_DRAW;
                        w_present = 1'b1;
                    end else begin
                        w_nxt = S_IDLE;
                    end
                end
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    // Erase works around the committed cursor; draw around the new one
    assign w_bx   = (w_nxt == S_ERASE) ? r_cx : w_new_x;
    assign w_by   = (w_nxt == S_ERASE) ? r_cy : w_new_y;
    assign w_bpix = (w_nxt == S_ERASE) ? ERASE_PIXEL : w_new_col;
    assign w_dx   = OFF_DX[w_pidx];
    assign w_dy   = OFF_DY[w_pidx];
    assign w_sx   = {1'b0, w_bx} + {{(X_W-1){w_dx[1]}}, w_dx};
    assign w_sy   = {1'b0, w_by} + {{(Y_W-1){w_dy[1]}}, w_dy};
    // Under- or overflow both land in the extra top bit
    assign w_in   = !w_sx[X_W] && !w_sy[Y_W];

    always_ff @(posedge GCLK) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_per   <= '0;
            r_valid <= 1'b0;
            r_color <= '0;
            r_idx   <= 3'd0;
            r_we    <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_pix   <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_start)
                r_per <= '0;
            else if (!w_per_hit)
                r_per <= r_per + PW'(1);
            if (w_present) begin
                r_idx <= w_pidx;
                r_we  <= w_in;
                if (w_in) begin
                    r_x   <= w_sx[X_W-1:0];
                    r_y   <= w_sy[Y_W-1:0];
                    r_pix <= w_bpix;
                end
            end else if (w_step) begin
                r_we <= 1'b0;
            end
            if (r_state == S_DRAW && w_step && w_last) begin
                r_cx    <= w_new_x;
                r_cy    <= w_new_y;
                r_color <= w_new_col;
                r_valid <= 1'b1;
            end
        end
    end

    assign fb_we    = r_we;
    assign fb_x     = r_x;
    assign fb_y     = r_y;
    assign fb_pixel = r_pix;
    assign cursor_x = r_cx;
    assign cursor_y = r_cy;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_trackball_cursor_plotter.sv
// Scoreboard bench: directed frames push expected writes, a negedge
// monitor pops and compares every accepted frame-buffer write.
module tb_trackball_cursor_plotter;

    logic        GCLK = 1'b0;
    logic        reset_n;
    logic        poll_en;
    logic [7:0]  tb_data;
    logic [1:0]  tb_adr;
    logic        fb_we;
    logic        fb_ready;
    logic [10:0] fb_x;
    logic [9:0]  fb_y;
    logic [11:0] fb_pixel;
    logic [10:0] cursor_x;
    logic [9:0]  cursor_y;
    logic        busy;

    logic [7:0] v_x, v_y, v_r, v_g;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic [11:0] p;
    } wr_t;

    wr_t q[$];
    int  checks  = 0;
    int  errors  = 0;
    int  n_wr    = 0;
    int  n_stall = 0;

    always #5 GCLK = ~GCLK;

    always_comb begin
        case (tb_adr)
            2'd0:    tb_data = v_x;
            2'd1:    tb_data = v_y;
            2'd2:    tb_data = v_r;
            default: tb_data = v_g;
        endcase
    end

    trackball_cursor_plotter #(.SETTLE(8), .POLL_PERIOD(114)) dut (
        .GCLK     (GCLK),
        .reset_n  (reset_n),
        .poll_en  (poll_en),
        .tb_data  (tb_data),
        .tb_adr   (tb_adr),
        .fb_we    (fb_we),
        .fb_ready (fb_ready),
        .fb_x     (fb_x),
        .fb_y     (fb_y),
        .fb_pixel (fb_pixel),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y),
        .busy     (busy)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting on DUT", name);
    endtask

    task automatic push(input int x, input int y, input logic [11:0] p);
        wr_t e;
        e.x = 11'(x);
        e.y = 10'(y);
        e.p = p;
        q.push_back(e);
    endtask

    // Monitor: compares accepted writes and holds stalled writes stable
    initial begin
        wr_t held, e;
        bit  st;
        st = 1'b0;
        held = '0;
        forever begin
            @(negedge GCLK);
            if (!reset_n) begin
                st = 1'b0;
            end else if (fb_we) begin
                if (st)
                    check("stall_stable", {fb_x, fb_y, fb_pixel}, held);
                if (!fb_ready) begin
                    st   = 1'b1;
                    held = {fb_x, fb_y, fb_pixel};
                    n_stall++;
                end else begin
                    st = 1'b0;
                    n_wr++;
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got %0d,%0d,%0h expected none",
                                 fb_x, fb_y, fb_pixel);
                    end else begin
                        e = q.pop_front();
                        check("wr_data", {fb_x, fb_y, fb_pixel}, e);
                    end
                end
            end else begin
                if (st)
                    check("we_dropped_in_stall", 64'(fb_we), 64'd1);
                st = 1'b0;
            end
        end
    end

    task automatic wait_busy(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge GCLK);
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("busy_rise");
    endtask

    task automatic run_frame(input logic [7:0] x, input logic [7:0] y,
                             input logic [7:0] r, input logic [7:0] g,
                             input int exp_wr, input bit lat);
        int base;
        bit ok;
        int h;
        int l;
        base = n_wr;
        v_x = x; v_y = y; v_r = r; v_g = g;
        poll_en = 1'b1;
        wait_busy(ok);
        poll_en = 1'b0;
        if (ok && lat) begin
            h = 0;
            for (int k = 0; k < 200 && tb_adr != 2'd3; k++) @(negedge GCLK);
            while (tb_adr == 2'd3 && h < 100) begin
                h++;
                @(negedge GCLK);
            end
            check("settle_hold", 64'(h), 64'd8);
            l = 0;
            while (!fb_we && l < 20) begin
                @(negedge GCLK);
                l++;
            end
            check("latency", 64'(l), 64'd1);
        end
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge GCLK);
        end
        if (!ok) timeout("busy_fall");
        check("wr_count", 64'(n_wr - base), 64'(exp_wr));
        check("queue_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic stall_second();
        int b;
        bit ok;
        b = n_wr;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (n_wr == b + 1) begin
                ok = 1'b1;
                break;
            end
            @(negedge GCLK);
        end
        if (!ok) begin
            timeout("stall_arm");
        end else begin
            @(posedge GCLK);
            #1 fb_ready = 1'b0;
            repeat (7) @(posedge GCLK);
            #1 fb_ready = 1'b1;
        end
    endtask

    initial begin
        bit ok;
        int base;
        reset_n  = 1'b0;
        poll_en  = 1'b0;
        fb_ready = 1'b1;
        v_x = 8'h00; v_y = 8'h00; v_r = 8'h00; v_g = 8'h00;
        repeat (3) @(posedge GCLK);
        @(negedge GCLK);
        check("reset_fb", {fb_we, fb_x, fb_y, fb_pixel}, 64'd0);
        check("reset_cur", {cursor_x, cursor_y, busy, tb_adr}, 64'd0);
        reset_n = 1'b1;

        // First frame: draw only, no erase
        push(128, 128, 12'hA5F); push(129, 128, 12'hA5F);
        push(127, 128, 12'hA5F); push(128, 129, 12'hA5F);
        push(128, 127, 12'hA5F);
        run_frame(8'h10, 8'h20, 8'hA0, 8'h50, 5, 1'b1);
        check("cursor_1", {cursor_x, cursor_y}, {11'd128, 10'd128});

        // Move right by one step: erase then draw
        push(128, 128, 12'h000); push(129, 128, 12'h000);
        push(127, 128, 12'h000); push(128, 129, 12'h000);
        push(128, 127, 12'h000);
        push(136, 128, 12'hA5F); push(137, 128, 12'hA5F);
        push(135, 128, 12'hA5F); push(136, 129, 12'hA5F);
        push(136, 127, 12'hA5F);
        run_frame(8'h11, 8'h20, 8'hA0, 8'h50, 10, 1'b0);
        check("cursor_2", {cursor_x, cursor_y}, {11'd136, 10'd128});

        // Identical frame: no writes
        run_frame(8'h11, 8'h20, 8'hA0, 8'h50, 0, 1'b0);
        check("cursor_3", {cursor_x, cursor_y}, {11'd136, 10'd128});

        // Origin: negative offsets skipped
        push(136, 128, 12'h000); push(137, 128, 12'h000);
        push(135, 128, 12'h000); push(136, 129, 12'h000);
        push(136, 127, 12'h000);
        push(0, 0, 12'hA5F); push(1, 0, 12'hA5F); push(0, 1, 12'hA5F);
        run_frame(8'h00, 8'h00, 8'hA0, 8'h50, 8, 1'b0);
        check("cursor_4", {cursor_x, cursor_y}, {11'd0, 10'd0});

        // Far corner
        push(0, 0, 12'h000); push(1, 0, 12'h000); push(0, 1, 12'h000);
        push(2040, 1020, 12'hA5F); push(2041, 1020, 12'hA5F);
        push(2039, 1020, 12'hA5F); push(2040, 1021, 12'hA5F);
        push(2040, 1019, 12'hA5F);
        run_frame(8'hFF, 8'hFF, 8'hA0, 8'h50, 8, 1'b0);
        check("cursor_5", {cursor_x, cursor_y}, {11'd2040, 10'd1020});

        // Back-pressure on the second write, new colour
        push(2040, 1020, 12'h000); push(2041, 1020, 12'h000);
        push(2039, 1020, 12'h000); push(2040, 1021, 12'h000);
        push(2040, 1019, 12'h000);
        push(256, 64, 12'h3CF); push(257, 64, 12'h3CF);
        push(255, 64, 12'h3CF); push(256, 65, 12'h3CF);
        push(256, 63, 12'h3CF);
        n_stall = 0;
        fork
            run_frame(8'h20, 8'h10, 8'h3C, 8'hC1, 10, 1'b0);
            stall_second();
        join
        check("stall_cycles", 64'(n_stall), 64'd7);
        check("cursor_6", {cursor_x, cursor_y}, {11'd256, 10'd64});

        // Reset in the middle of the draw pass
        push(256, 64, 12'h000); push(257, 64, 12'h000);
        push(255, 64, 12'h000); push(256, 65, 12'h000);
        push(256, 63, 12'h000);
        push(384, 120, 12'h3CF); push(385, 120, 12'h3CF);
        push(383, 120, 12'h3CF); push(384, 121, 12'h3CF);
        push(384, 119, 12'h3CF);
        base = n_wr;
        v_x = 8'h30; v_y = 8'h1E; v_r = 8'h3C; v_g = 8'hC1;
        poll_en = 1'b1;
        wait_busy(ok);
        poll_en = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (n_wr == base + 7) begin
                ok = 1'b1;
                break;
            end
            @(negedge GCLK);
        end
        if (!ok) timeout("mid_draw");
        reset_n = 1'b0;
        @(posedge GCLK);
        #1;
        check("midrst_fb", {fb_we, fb_x, fb_y, fb_pixel}, 64'd0);
        check("midrst_cur", {cursor_x, cursor_y, busy, tb_adr}, 64'd0);
        q.delete();
        @(negedge GCLK);
        reset_n = 1'b1;

        // First frame after reset draws without erase
        push(384, 120, 12'h3CF); push(385, 120, 12'h3CF);
        push(383, 120, 12'h3CF); push(384, 121, 12'h3CF);
        push(384, 119, 12'h3CF);
        run_frame(8'h30, 8'h1E, 8'h3C, 8'hC1, 5, 1'b0);
        check("cursor_7", {cursor_x, cursor_y}, {11'd384, 10'd120});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
